// File: rtl/tiger_writeback_mc.sv
// Tiger multi-channel writeback: per-channel result FIFOs merged onto the single
// register-file write port by a fixed-priority arbiter with a starvation guard.
module tiger_writeback_mc #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 32,
    parameter int REGNUM_W   = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 7
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  logic [NUM_CH*REGNUM_W-1:0]   in_regnum,
    input  logic [NUM_CH*DATA_W-1:0]     in_data,
    input  logic [NUM_CH-1:0]            in_cop,
    input  logic                         ch0_link,
    input  logic [DATA_W-1:0]            ch0_branchout,
    input  logic [REGNUM_W-1:0]          query_regnum,
    output logic                         query_busy,
    output logic                         writeRegEn,
    output logic                         writeRegEnCop,
    output logic [REGNUM_W-1:0]          writeRegNum,
    output logic [DATA_W-1:0]            writeRegData
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int IDX_W = $clog2(NUM_CH);

    typedef struct packed {
        logic [REGNUM_W-1:0] regnum;
        logic [DATA_W-1:0]   data;
        logic                cop;
    } entry_t;

    entry_t            mem    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr [NUM_CH];
    logic [CNT_W-1:0]  count  [NUM_CH];
    logic [ST_W-1:0]   starve [NUM_CH];
    entry_t            din    [NUM_CH];

    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] nonempty;
    logic              gnt_any;
    logic [IDX_W-1:0]  gnt_idx;
    entry_t            head;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
    always_comb begin
        in_ready = '0;
        nonempty = '0;
        push     = '0;
        din      = '{default: '0};
        for (int c = 0; c < NUM_CH; c++) begin
            in_ready[c]   = (count[c] != CNT_W'(DEPTH));
            nonempty[c]   = (count[c] != '0);
            push[c]       = in_valid[c] & in_ready[c];
            din[c].regnum = in_regnum[c*REGNUM_W +: REGNUM_W];
            din[c].data   = (c == 0 && ch0_link) ? ch0_branchout : in_data[c*DATA_W +: DATA_W];
            din[c].cop    = in_cop[c];
        end
    end

    // Lowest non-empty channel wins unless a starved channel forces its way in.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (nonempty[c]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(c);
            end
        end
        for (int c = NUM_CH - 1; c >= 1; c--) begin
            if (nonempty[c] && starve[c] == ST_W'(STARVE_MAX)) begin
                gnt_idx = IDX_W'(c);
            end
        end
        pop  = gnt_any ? (NUM_CH'(1) << gnt_idx) : '0;
        head = mem[gnt_idx][rd_ptr[gnt_idx]];
    end

    always_comb begin
        logic [PTR_W-1:0] off;
        off        = '0;
        query_busy = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < DEPTH; i++) begin
                off = PTR_W'(i) - rd_ptr[c];
                if (({1'b0, off} < count[c]) && !mem[c][i].cop &&
                    (mem[c][i].regnum == query_regnum)) begin
                    query_busy = 1'b1;
                end
            end
        end
        if (writeRegEn && writeRegNum == query_regnum) begin
            query_busy = 1'b1;
        end
        if (query_regnum == '0) begin
            query_busy = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) begin
                mem[c][wr_ptr[c]] <= din[c];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
                starve[c] <= '0;
            end
            writeRegEn    <= 1'b0;
            writeRegEnCop <= 1'b0;
            writeRegNum   <= '0;
            writeRegData  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
                case ({push[c], pop[c]})
                    2'b10:   count[c] <= count[c] + CNT_W'(1);
                    2'b01:   count[c] <= count[c] - CNT_W'(1);
                    default: count[c] <= count[c];
                endcase
                if (c == 0 || !nonempty[c] || pop[c]) begin
                    starve[c] <= '0;
                end else if (starve[c] != ST_W'(STARVE_MAX)) begin
                    starve[c] <= starve[c] + ST_W'(1);
                end
            end
            // r0 GPR writes are drained like any entry but never enabled.
            if (gnt_any) begin
                writeRegNum   <= head.regnum;
                writeRegData  <= head.data;
                writeRegEnCop <= head.cop;
                writeRegEn    <= !head.cop && (head.regnum != '0);
            end else begin
                writeRegEn    <= 1'b0;
                writeRegEnCop <= 1'b0;
            end
        end
    end

endmodule
